bounce_seq_checker: RTL and testbench
=====================================

Name: bounce_seq_checker

Overview:
- Receive-side checker for the 4-bit bouncing up/down counter stream: 0,1,…,15,14,…,0,1,…
- Samples the counter value each enabled clock, locks onto the sequence and infers the count direction.
- Flags every step that breaks the bounce rule, and counts errors and turnarounds.
- Sits beside the counter in the exercise top level as its self-check monitor.

Parameters:
WIDTH, 4, bit width of the observed count; MAXV = 2**WIDTH-1 is the top turnaround value.
CNT_W, 8, width of the saturating err_count and turn_count registers.

Ports:
clk  input  1  single clock, all state updates on posedge
reset  input  1  one clock; reset is asynchronous and active-low
valid  input  1  cont_in is a new sample this cycle; when low, all state holds
cont_in  input  WIDTH  observed counter value
clr  input  1  synchronous clear of err_count and turn_count only; does not affect lock
locked  output  1  checker is tracking the sequence
dir  output  1  inferred direction: 0 = up, 1 = down; meaningful only while locked=1
err  output  1  one-cycle pulse, asserted the cycle after a bad sample
err_count  output  CNT_W  saturating count of errors
turn_count  output  CNT_W  saturating count of correct turnarounds (15->14 and 0->1)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE
  - locked=0, dir=0, err=0, err_count=0, turn_count=0
  - the prev register is cleared to 0.
- All outputs are registered. Every decision is made on a cycle with valid=1 and appears on the next posedge.
- While valid=0: state, prev, dir, counts and locked hold; err=0.
- FSM states: IDLE, ACQ, LOCK.
- IDLE, valid=1: prev<=cont_in, go to ACQ. No err.
- ACQ, valid=1. Compare against prev without wrap arithmetic:
  - cont_in==prev+1 (requires prev<MAXV): dir<=0, go to LOCK, locked<=1.
  - cont_in==prev-1 (requires prev>0): dir<=1, go to LOCK, locked<=1.
  - Otherwise: err pulse, err_count++, stay in ACQ.
  - prev<=cont_in in all three cases.
  - 15->14 in ACQ locks with dir=1; 0->1 locks with dir=0. Neither counts as a turnaround, because direction was not yet known.
- LOCK, valid=1, expected value exp:
  - dir=0: exp = (prev==MAXV) ? MAXV-1 : prev+1. At prev==MAXV the next dir is 1.
  - dir=1: exp = (prev==0) ? 1 : prev-1. At prev==0 the next dir is 0.
  - cont_in==exp: prev<=cont_in and dir updates as above. If this step was a turnaround, turn_count++.
  - cont_in!=exp: err pulse, err_count++, locked<=0, go to ACQ, prev<=cont_in (re-acquire from the bad sample).
- Counters saturate at 2**CNT_W-1 and never wrap.
- clr=1 zeroes err_count and turn_count on that edge, and takes priority over any increment in the same cycle. FSM, dir and err are unaffected.
- Repeated value (cont_in==prev) is always an error, in both ACQ and LOCK. This covers a stuck counter.
- Reset asserted mid-sequence returns the checker to IDLE at once. The first post-reset sample must pass through ACQ again before lock.

Test Plan:
- Reset then feed valid=1 with 0,1,2,…,15,14,…,0,1 → locked=1 from the edge after the 2nd sample; dir=0 while counting up; dir=1 after 15->14; turn_count=2 after 0->1; err never asserted.
- While locked going up, inject 7,8,10 → err=1 for exactly one cycle after 10; err_count=1; locked=0. Then 9,8 → relock with dir=1; err_count stays 1.
- Stuck value: 5,5,5 from IDLE → 2 errors (on the 2nd and 3rd samples); locked stays 0.
- Gaps: stream 3,4 with valid=0 for 3 cycles, then 5 → no err; locked=1; dir=0. Outputs hold during the gap.
- Saturation/clear with CNT_W=2: force 5 errors → err_count=3. Assert clr together with a 6th error → err_count=0 on that edge.
- Async reset: assert reset=0 mid-cycle while locked=1 and dir=1 → locked, dir and counts all go to 0 before the next posedge. After release, first sample 15 then 14 → lock with dir=1; turn_count=0.

Source files
------------

// File: rtl/bounce_seq_checker.sv
// Receive-side monitor for a bouncing up/down counter stream (0..MAXV..0..).
// Locks onto the sequence, infers direction, flags bad steps and counts errors/turnarounds.
module bounce_seq_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] cont_in,
    input  logic             clr,
    output logic             locked,
    output logic             dir,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] turn_count
);

    localparam logic [WIDTH-1:0] MAXV    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCK
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] prev, prev_nx;
    logic [WIDTH-1:0] prev_inc, prev_dec, exp_val;
    logic             dir_nx, locked_nx, err_nx, turn_nx, at_turn;

    assign prev_inc = prev + ONE;
    assign prev_dec = prev - ONE;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state  <= IDLE;
            prev   <= '0;
            dir    <= 1'b0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            prev   <= prev_nx;
            dir    <= dir_nx;
            locked <= locked_nx;
            err    <= err_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx  = state;
        prev_nx   = prev;
        dir_nx    = dir;
        locked_nx = locked;
        err_nx    = 1'b0;
        turn_nx   = 1'b0;
        at_turn   = 1'b0;
        exp_val   = '0;

        if (valid) begin
            unique case (state)
                IDLE: begin
                    prev_nx  = cont_in;
                    state_nx = ACQ;
                end
                ACQ: begin
                    // No wrap arithmetic: MAXV->0 and 0->MAXV are errors, never a lock.
                    prev_nx = cont_in;
                    if (prev != MAXV && cont_in == prev_inc) begin
                        dir_nx    = 1'b0;
                        locked_nx = 1'b1;
                        state_nx  = LOCK;
                    end else if (prev != '0 && cont_in == prev_dec) begin
                        dir_nx    = 1'b1;
                        locked_nx = 1'b1;
                        state_nx  = LOCK;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                LOCK: begin
                    if (!dir) begin
                        at_turn = (prev == MAXV);
                        exp_val = at_turn ? (MAXV - ONE) : prev_inc;
                    end else begin
                        at_turn = (prev == '0);
                        exp_val = at_turn ? ONE : prev_dec;
                    end
                    prev_nx = cont_in;
                    if (cont_in == exp_val) begin
                        if (at_turn) begin
                            dir_nx  = ~dir;
                            turn_nx = 1'b1;
                        end
                    end else begin
                        // Re-acquire starting from the bad sample itself.
                        err_nx    = 1'b1;
                        locked_nx = 1'b0;
                        state_nx  = ACQ;
                    end
                end
                default: begin
                    state_nx  = IDLE;
                    locked_nx = 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle increment; both counters saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count  <= '0;
            turn_count <= '0;
        end else if (clr) begin
            err_count  <= '0;
            turn_count <= '0;
        end else begin
            if (err_nx && err_count != CNT_MAX)
                err_count <= err_count + CNT_ONE;
            if (turn_nx && turn_count != CNT_MAX)
                turn_count <= turn_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_bounce_seq_checker.sv
// Directed self-checking bench for bounce_seq_checker; a CNT_W=2 instance shares
// the stimulus to exercise counter saturation.
module tb_bounce_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] cont_in = '0;
    logic       clr = 1'b0;

    logic       locked, dir, err;
    logic [7:0] err_count, turn_count;
    logic       locked2, dir2, err2;
    logic [1:0] err_count2, turn_count2;

    int n_checks = 0;
    int n_fail   = 0;

    bounce_seq_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .valid(valid), .cont_in(cont_in), .clr(clr),
        .locked(locked), .dir(dir), .err(err),
        .err_count(err_count), .turn_count(turn_count)
    );

    bounce_seq_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .valid(valid), .cont_in(cont_in), .clr(clr),
        .locked(locked2), .dir(dir2), .err(err2),
        .err_count(err_count2), .turn_count(turn_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Present one valid sample across one posedge; outputs are sampled 1 ns later.
    task automatic step(input logic [3:0] v);
        valid   = 1'b1;
        cont_in = v;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic gap();
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        #2;
        check("rst_locked", locked, 0);
        check("rst_dir", dir, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_turn_count", turn_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Full bounce 0..15..0,1
        step(4'd0);
        check("seq_first_unlocked", locked, 0);
        for (int v = 1; v <= 15; v++) begin
            step(4'(v));
            check("seq_up_locked", locked, 1);
            check("seq_up_dir", dir, 0);
            check("seq_up_err", err, 0);
        end
        check("seq_top_turn_count", turn_count, 0);
        for (int v = 14; v >= 0; v--) begin
            step(4'(v));
            check("seq_dn_dir", dir, 1);
            check("seq_dn_err", err, 0);
        end
        check("seq_turn_count_1", turn_count, 1);
        step(4'd1);
        check("seq_bottom_dir", dir, 0);
        check("seq_turn_count_2", turn_count, 2);
        check("seq_err_count", err_count, 0);

        // Skip error while locked up: ...,7,8,10 then 9,8
        for (int v = 2; v <= 8; v++) step(4'(v));
        check("skip_pre_err", err, 0);
        step(4'd10);
        check("skip_err", err, 1);
        check("skip_err_count", err_count, 1);
        check("skip_unlocked", locked, 0);
        step(4'd9);
        check("skip_err_one_cycle", err, 0);
        check("skip_relock", locked, 1);
        check("skip_relock_dir", dir, 1);
        step(4'd8);
        check("skip_still_locked", locked, 1);
        check("skip_err_count_hold", err_count, 1);
        check("skip_turn_count_hold", turn_count, 2);

        // Stuck value from IDLE
        do_reset();
        step(4'd5);
        check("stuck_s1_err", err, 0);
        step(4'd5);
        check("stuck_s2_err", err, 1);
        check("stuck_s2_count", err_count, 1);
        step(4'd5);
        check("stuck_s3_err", err, 1);
        check("stuck_s3_count", err_count, 2);
        check("stuck_unlocked", locked, 0);

        // Gaps in valid
        do_reset();
        step(4'd3);
        step(4'd4);
        check("gap_locked", locked, 1);
        for (int i = 0; i < 3; i++) begin
            gap();
            check("gap_hold_locked", locked, 1);
            check("gap_hold_dir", dir, 0);
            check("gap_hold_err", err, 0);
        end
        step(4'd5);
        check("gap_after_err", err, 0);
        check("gap_after_locked", locked, 1);
        check("gap_after_dir", dir, 0);

        // Saturation (CNT_W=2) and clear priority
        do_reset();
        step(4'd5);
        for (int i = 1; i <= 5; i++) begin
            step(4'd5);
            check("sat_err_count8", err_count, 32'(i));
            check("sat_err_count2", err_count2, (i > 3) ? 3 : 32'(i));
        end
        clr = 1'b1;
        step(4'd5);
        clr = 1'b0;
        check("clr_err_still_pulses", err, 1);
        check("clr_err_count8", err_count, 0);
        check("clr_err_count2", err_count2, 0);

        // Async reset mid-cycle while locked going down
        do_reset();
        step(4'd14);
        step(4'd14);
        step(4'd15);
        step(4'd14);
        check("ar_pre_locked", locked, 1);
        check("ar_pre_dir", dir, 1);
        check("ar_pre_err_count", err_count, 1);
        check("ar_pre_turn_count", turn_count, 1);
        #3;
        reset = 1'b0;
        #1;
        check("ar_locked", locked, 0);
        check("ar_dir", dir, 0);
        check("ar_err_count", err_count, 0);
        check("ar_turn_count", turn_count, 0);
        #2;
        reset = 1'b1;
        step(4'd15);
        check("ar_first_unlocked", locked, 0);
        check("ar_first_err", err, 0);
        step(4'd14);
        check("ar_relock", locked, 1);
        check("ar_relock_dir", dir, 1);
        check("ar_relock_turn", turn_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
